// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: forwarding selects, load-use stall, branch flush and data-memory wait.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
    parameter int REG_ADDR_W   = 4,
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] RA1D,
    input  logic [REG_ADDR_W-1:0] RA2D,
    input  logic [REG_ADDR_W-1:0] RA1E,
    input  logic [REG_ADDR_W-1:0] RA2E,
    input  logic [REG_ADDR_W-1:0] WA3E,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic [REG_ADDR_W-1:0] WA3W,
    input  logic                  MemtoRegE,
    input  logic                  RegWM,
    input  logic                  RegWW,
    input  logic                  BranchTakenE,
    input  logic                  MemWM,
    input  logic                  MemtoRegM,
    input  logic                  MemAck,
    output logic                  MemReq,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
`ifdef HAZARD_PERF_CNT_EN
    output logic                  MemTimeout,
    output logic [15:0]           StallCycles,
    output logic [15:0]           FlushEvents
`else
    output logic                  MemTimeout
`endif
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } state_t;

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;

    logic mem_acc, ld_use;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic mem_req;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWM && (WA3M == RA1E))
            ForwardAE = 2'b10;
        else if (RegWW && (WA3W == RA1E))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWM && (WA3M == RA2E))
            ForwardBE = 2'b10;
        else if (RegWW && (WA3W == RA2E))
            ForwardBE = 2'b01;
    end

    assign mem_acc = MemWM | MemtoRegM;
    assign ld_use  = MemtoRegE & ((WA3E == RA1D) | (WA3E == RA2D));

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_w       = 1'b0;
        mem_req       = 1'b0;
        case (state)
            RUN: begin
                mem_req = mem_acc;
                if (mem_acc && !MemAck) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 8'd1;
                    stall_f       = 1'b1;
                    stall_d       = 1'b1;
                    stall_e       = 1'b1;
                    stall_m       = 1'b1;
                    flush_w       = 1'b1;
                end else if (BranchTakenE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (ld_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                if (MemAck) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                    if (wait_cnt == 8'(MAX_MEM_WAIT))
                        state_next = ERROR;
                    else
                        wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            ERROR: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state_next == ERROR)
                MemTimeout <= 1'b1;
        end
    end

    // Pipeline controls are forced quiet while reset is held, independent of state.
    assign StallF = rst & stall_f;
    assign StallD = rst & stall_d;
    assign StallE = rst & stall_e;
    assign StallM = rst & stall_m;
    assign FlushD = rst & flush_d;
    assign FlushE = rst & flush_e;
    assign FlushW = rst & flush_w;
    assign MemReq = rst & mem_req;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            if (StallF && (StallCycles != '1))
                StallCycles <= StallCycles + 16'd1;
            if (FlushE && (FlushEvents != '1))
                FlushEvents <= FlushEvents + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a rule-level reference model checked every cycle.
module tb_hazard_control_unit;

    localparam int AW   = 4;
    localparam int MAXW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          MemtoRegE, RegWM, RegWW, BranchTakenE, MemWM, MemtoRegM, MemAck;
    logic          MemReq;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0]   StallCycles, FlushEvents;
`endif

    hazard_control_unit #(.REG_ADDR_W(AW), .MAX_MEM_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .MemtoRegE(MemtoRegE), .RegWM(RegWM), .RegWW(RegWW),
        .BranchTakenE(BranchTakenE), .MemWM(MemWM), .MemtoRegM(MemtoRegM),
        .MemAck(MemAck), .MemReq(MemReq),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
`ifdef HAZARD_PERF_CNT_EN
        .MemTimeout(MemTimeout),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents)
`else
        .MemTimeout(MemTimeout)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // ctrl bits: {SF,SD,SE,SM,FD,FE,FW,Req,Timeout}
    logic [8:0] act_ctrl;
    assign act_ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReq, MemTimeout};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding access flag, count of no-ack cycles so far, dead (timed out).
    logic m_pending = 1'b0;
    logic m_dead    = 1'b0;
    int   m_miss    = 0;
    logic [15:0] m_sc = '0, m_fe = '0;

    function automatic logic [1:0] fwd(input logic [AW-1:0] src);
        if (RegWM && WA3M == src) return 2'b10;
        if (RegWW && WA3W == src) return 2'b01;
        return 2'b00;
    endfunction

    logic [1:0] e_fa, e_fb;
    logic [8:0] e_ctrl;
    always_comb begin
        e_fa   = fwd(RA1E);
        e_fb   = fwd(RA2E);
        e_ctrl = '0;
        if (!rst)
            e_ctrl = {8'b0, m_dead};
        else if (m_dead)
            e_ctrl = 9'b111100001;
        else if (m_pending)
            e_ctrl = MemAck ? 9'b000000010 : 9'b111100110;
        else if ((MemWM || MemtoRegM) && !MemAck)
            e_ctrl = 9'b111100110;
        else begin
            e_ctrl[1] = MemWM || MemtoRegM;
            if (BranchTakenE)
                e_ctrl[4:3] = 2'b11;
            else if (MemtoRegE && (WA3E == RA1D || WA3E == RA2D)) begin
                e_ctrl[8:7] = 2'b11;
                e_ctrl[3]   = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_pending <= 1'b0;
            m_dead    <= 1'b0;
            m_miss    <= 0;
            m_sc      <= '0;
            m_fe      <= '0;
        end else begin
            if (e_ctrl[8] && m_sc != 16'hFFFF) m_sc <= m_sc + 16'd1;
            if (e_ctrl[3] && m_fe != 16'hFFFF) m_fe <= m_fe + 16'd1;
            if (!m_dead) begin
                if (m_pending) begin
                    if (MemAck) begin
                        m_pending <= 1'b0;
                        m_miss    <= 0;
                    end else if (m_miss + 1 > MAXW) begin
                        m_dead    <= 1'b1;
                        m_pending <= 1'b0;
                    end else
                        m_miss <= m_miss + 1;
                end else if ((MemWM || MemtoRegM) && !MemAck) begin
                    m_pending <= 1'b1;
                    m_miss    <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("fwdA", 32'(ForwardAE), 32'(e_fa));
            check("fwdB", 32'(ForwardBE), 32'(e_fb));
            check("ctrl", 32'(act_ctrl), 32'(e_ctrl));
`ifdef HAZARD_PERF_CNT_EN
            check("stall_cycles", 32'(StallCycles), 32'(m_sc));
            check("flush_events", 32'(FlushEvents), 32'(m_fe));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        RA1D = 4'd1; RA2D = 4'd2; RA1E = 4'd1; RA2E = 4'd2;
        WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
        {MemtoRegE, RegWM, RegWW, BranchTakenE, MemWM, MemtoRegM, MemAck} = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        step(1);
        chk_en = 1'b1;
        step(1);
        check("reset_ctrl", 32'(act_ctrl), 32'(9'b0));
        rst = 1'b1;
        step(1);

        // Forwarding priority
        RegWM = 1; WA3M = 4'd3; RegWW = 1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd5;
        #1;
        check("fwdA_M", 32'(ForwardAE), 32'(2'b10));
        check("fwdB_none", 32'(ForwardBE), 32'(2'b00));
        step(1);
        RegWM = 0;
        #1;
        check("fwdA_W", 32'(ForwardAE), 32'(2'b01));
        step(1);
        RA2E = 4'd3; RegWM = 1; WA3M = 4'd7;
        step(1);
        idle();

        // Load-use on RA2D, then RA1D, then cleared
        MemtoRegE = 1; WA3E = 4'd4; RA2D = 4'd4;
        #1;
        check("lduse", 32'(act_ctrl), 32'(9'b110001000));
        step(1);
        RA2D = 4'd2; RA1D = 4'd4;
        step(1);
        MemtoRegE = 0;
        #1;
        check("lduse_clear", 32'(act_ctrl), 32'(9'b0));
        step(1);

        // Branch wins over load-use
        MemtoRegE = 1; WA3E = 4'd4; RA2D = 4'd4; BranchTakenE = 1;
        #1;
        check("branch", 32'(act_ctrl), 32'(9'b000011000));
        step(1);
        idle();
        step(1);

        // Memory wait: 3 no-ack cycles then ack; branch/load-use suppressed while waiting
        MemtoRegM = 1;
        #1;
        check("wait_c1", 32'(act_ctrl), 32'(9'b111100110));
        step(1);
        BranchTakenE = 1; MemtoRegE = 1; WA3E = 4'd1;
        step(1);
        BranchTakenE = 0; MemtoRegE = 0;
        step(1);
        MemAck = 1;
        #1;
        check("wait_ack", 32'(act_ctrl), 32'(9'b000000010));
        step(1);
        idle();
        #1;
        check("wait_back_run", 32'(act_ctrl), 32'(9'b0));
        step(1);

        // Zero-wait store, then stray ack with no request
        MemWM = 1; MemAck = 1;
        #1;
        check("zero_wait", 32'(act_ctrl), 32'(9'b000000010));
        step(1);
        MemWM = 0;
        step(2);
        idle();
        step(1);

        // Timeout: 16 no-ack cycles then ERROR
        MemWM = 1;
        step(15);
        check("pre_timeout", 32'(act_ctrl), 32'(9'b111100110));
        step(1);
        check("error", 32'(act_ctrl), 32'(9'b111100001));
        MemWM = 0; MemAck = 1; BranchTakenE = 1;
        step(2);
        check("error_sticky", 32'(act_ctrl), 32'(9'b111100001));
        idle();
        rst = 1'b0;
        #1;
        check("error_rst_low", 32'(act_ctrl), 32'(9'b000000001));
        step(1);
        check("error_cleared", 32'(act_ctrl), 32'(9'b0));
        rst = 1'b1;
        step(1);

        // Reset mid-wait clears the counter
        MemtoRegM = 1;
        step(3);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        MemtoRegM = 0;
        #1;
        check("midwait_rst", 32'(act_ctrl), 32'(9'b0));
        step(1);
        MemWM = 1;
        step(15);
        check("midwait_no_timeout", 32'(act_ctrl), 32'(9'b111100110));
        MemAck = 1;
        step(1);
        idle();
        step(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
